// File: rtl/tmds_pkg.sv
// Shared types and control tokens for the TMDS channel encoder.
package tmds_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SYM_W   = 10;
    localparam int unsigned QM_W    = 9;
    localparam int unsigned COUNT_W = 4;

    typedef logic signed [4:0]  tally_t;
    typedef logic [SYM_W-1:0]   tmds_sym_t;

    localparam tmds_sym_t CTRL_TOKEN_00 = 10'b1101010100;
    localparam tmds_sym_t CTRL_TOKEN_01 = 10'b0010101011;
    localparam tmds_sym_t CTRL_TOKEN_10 = 10'b0101010100;
    localparam tmds_sym_t CTRL_TOKEN_11 = 10'b1010101011;

endpackage

// File: rtl/tm_choice.sv
// Transition-minimization stage: picks an XOR or XNOR chain over the byte
// and flags the choice in q_m[8] (1 = XOR).
module tm_choice
    import tmds_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    output logic [QM_W-1:0]   q_m
);

    logic [COUNT_W-1:0] ones;
    logic [DATA_W-1:0]  xor_chain;
    logic               use_xnor;
    logic               acc;

    // The XNOR chain equals the XOR prefix-parity chain with odd bits inverted.
    always_comb begin
        ones      = '0;
        acc       = 1'b0;
        xor_chain = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            ones         = ones + COUNT_W'(d[i]);
            acc          = acc ^ d[i];
            xor_chain[i] = acc;
        end
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q_m[DATA_W-1:0] = use_xnor ? (xor_chain ^ 8'b1010_1010) : xor_chain;
        q_m[QM_W-1]     = !use_xnor;
    end

endmodule

// File: rtl/tmds_encoder.sv
// DC-balanced TMDS channel encoder, one symbol per clock.
// Define TMDS_ENCODER_OUTREG_EN to add a second output register (latency 2).
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        control_in,
    input  logic              ve_in,
    output logic [SYM_W-1:0]  tmds_out
);

    logic [QM_W-1:0]    q_m;
    logic [COUNT_W-1:0] n1;
    logic [COUNT_W-1:0] n0;
    tally_t             diff;
    tally_t             tally_d, tally_q;
    tmds_sym_t          sym_d, sym_q;
    logic               tally_pos;
    logic               tally_neg;

    tm_choice u_tm_choice (
        .d   (data_in),
        .q_m (q_m)
    );

    // Popcount, disparity case selection and next tally.
    always_comb begin
        sym_d     = '0;
        tally_d   = tally_q;
        n1        = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            n1 = n1 + COUNT_W'(q_m[i]);
        end
        n0        = COUNT_W'(4'd8 - n1);
        diff      = tally_t'(n1) - tally_t'(n0);
        tally_neg = tally_q[4];
        tally_pos = !tally_q[4] && (tally_q != '0);

        if (!ve_in) begin
            tally_d = '0;
            case (control_in)
                2'b00:   sym_d = CTRL_TOKEN_00;
                2'b01:   sym_d = CTRL_TOKEN_01;
                2'b10:   sym_d = CTRL_TOKEN_10;
                default: sym_d = CTRL_TOKEN_11;
            endcase
        end else if ((tally_q == '0) || (n1 == 4'd4)) begin
            sym_d   = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            tally_d = q_m[8] ? (tally_q + diff) : (tally_q - diff);
        end else if ((tally_pos && (n1 > n0)) || (tally_neg && (n0 > n1))) begin
            sym_d   = {1'b1, q_m[8], ~q_m[7:0]};
            tally_d = tally_q + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            sym_d   = {1'b0, q_m[8], q_m[7:0]};
            tally_d = tally_q + diff - (q_m[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sym_q   <= '0;
            tally_q <= '0;
        end else begin
            sym_q   <= sym_d;
            tally_q <= tally_d;
        end
    end

`ifdef TMDS_ENCODER_OUTREG_EN
    tmds_sym_t out_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_q <= '0;
        end else begin
            out_q <= sym_q;
        end
    end

    assign tmds_out = out_q;
`else
    assign tmds_out = sym_q;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and random checks of tmds_encoder against hand values and a golden model.
module tb_tmds_encoder;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] data_in;
    logic [1:0] control_in;
    logic       ve_in;
    logic [9:0] tmds_out;

`ifdef TMDS_ENCODER_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] s1 = '0;
    logic [9:0] s2 = '0;
    logic [9:0] exp_out = '0;

    tmds_encoder dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .data_in    (data_in),
        .control_in (control_in),
        .ve_in      (ve_in),
        .tmds_out   (tmds_out)
    );

    always #5 clk_in = ~clk_in;

    // Drive one cycle; sym is the symbol the first register stage should capture.
    task automatic step(input logic rst, input logic ve, input logic [1:0] ctrl,
                        input logic [7:0] d, input logic [9:0] sym);
        rst_in     = rst;
        ve_in      = ve;
        control_in = ctrl;
        data_in    = d;
        @(posedge clk_in);
        #1;
        if (rst) begin
            s1 = '0;
            s2 = '0;
        end else begin
            s2 = s1;
            s1 = sym;
        end
        exp_out = (LAT == 2) ? s2 : s1;
    endtask

    // Textbook DVI encoder used as the golden reference.
    function automatic void enc_model(input logic [7:0] d, input logic ve,
                                      input logic [1:0] c, inout int t,
                                      output logic [9:0] sym);
        logic [8:0] qm;
        int         cnt, n1, n0;
        logic       xn;
        if (!ve) begin
            t = 0;
            case (c)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            return;
        end
        cnt   = $countones(d);
        xn    = (cnt > 4) || (cnt == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = !xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (t == 0 || n1 == n0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            t   = qm[8] ? t + n1 - n0 : t + n0 - n1;
        end else if ((t > 0 && n1 > n0) || (t < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            t   = t + 2 * int'(qm[8]) + n0 - n1;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            t   = t + n1 - n0 - (qm[8] ? 0 : 2);
        end
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'b00, 8'hA5, 10'h000);
            n_vec++;
            if (tmds_out !== 10'h000) begin
                n_err++;
                $display("FAIL reset_sym[%0d]: got %h expected 000", i, tmds_out);
            end
            n_vec++;
            if (int'(dut.tally_q) != 0) begin
                n_err++;
                $display("FAIL reset_tally[%0d]: got %0d expected 0", i, int'(dut.tally_q));
            end
        end
    endtask

    task automatic test_disparity();
        logic [9:0] es [3] = '{10'h100, 10'h3FF, 10'h100};
        int         et [3] = '{-8, 2, -6};
        step(1'b1, 1'b1, 2'b00, 8'h00, 10'h000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'b00, 8'h00, es[i]);
            n_vec++;
            if (tmds_out !== exp_out) begin
                n_err++;
                $display("FAIL disp_sym[%0d]: got %h expected %h", i, tmds_out, exp_out);
            end
            n_vec++;
            if (int'(dut.tally_q) != et[i]) begin
                n_err++;
                $display("FAIL disp_tally[%0d]: got %0d expected %0d", i, int'(dut.tally_q), et[i]);
            end
        end
    endtask

    task automatic test_all_ones();
        step(1'b1, 1'b1, 2'b00, 8'h00, 10'h000);
        step(1'b0, 1'b1, 2'b00, 8'hFF, 10'h200);
        n_vec++;
        if (dut.q_m !== 9'h0FF) begin
            n_err++;
            $display("FAIL ones_qm: got %h expected 0ff", dut.q_m);
        end
        n_vec++;
        if (tmds_out !== exp_out) begin
            n_err++;
            $display("FAIL ones_sym: got %h expected %h", tmds_out, exp_out);
        end
        n_vec++;
        if (int'(dut.tally_q) != -8) begin
            n_err++;
            $display("FAIL ones_tally: got %0d expected -8", int'(dut.tally_q));
        end
    endtask

    task automatic test_control();
        logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 2'(i), 8'h5A, tok[i]);
            n_vec++;
            if (tmds_out !== exp_out) begin
                n_err++;
                $display("FAIL ctrl_sym[%0d]: got %h expected %h", i, tmds_out, exp_out);
            end
            n_vec++;
            if (int'(dut.tally_q) != 0) begin
                n_err++;
                $display("FAIL ctrl_tally[%0d]: got %0d expected 0", i, int'(dut.tally_q));
            end
        end
        // Flush the pipeline so the last token is observed with either latency.
        step(1'b0, 1'b1, 2'b00, 8'h00, 10'h100);
        n_vec++;
        if (tmds_out !== exp_out) begin
            n_err++;
            $display("FAIL ctrl_flush: got %h expected %h", tmds_out, exp_out);
        end
    endtask

    // kind 0: blanking gap mid-stream; kind 1: reset pulse mid-stream.
    task automatic test_midstream(input int kind);
        logic [9:0] es [5] = '{10'h100, 10'h3FF, 10'h100, 10'h354, 10'h100};
        int         et [5] = '{-8, 2, -6, 0, -8};
        step(1'b1, 1'b1, 2'b00, 8'h00, 10'h000);
        for (int i = 0; i < 6; i++) begin
            if (i == 3)
                step(kind == 1, kind == 1, 2'b00, 8'h00, es[i]);
            else if (i == 5)
                step(1'b0, 1'b0, 2'b01, 8'h00, 10'h0AB);
            else
                step(1'b0, 1'b1, 2'b00, 8'h00, es[i]);
            n_vec++;
            if (tmds_out !== exp_out) begin
                n_err++;
                $display("FAIL mid%0d_sym[%0d]: got %h expected %h", kind, i, tmds_out, exp_out);
            end
            if (i < 5) begin
                n_vec++;
                if (int'(dut.tally_q) != et[i]) begin
                    n_err++;
                    $display("FAIL mid%0d_tally[%0d]: got %0d expected %0d",
                             kind, i, int'(dut.tally_q), et[i]);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        int         mt = 0;
        int         t;
        logic [9:0] sym;
        logic [7:0] d;
        logic [1:0] c;
        logic       ve;
        step(1'b1, 1'b1, 2'b00, 8'h00, 10'h000);
        for (int i = 0; i < 10000; i++) begin
            d  = 8'($urandom);
            c  = 2'($urandom);
            ve = ($urandom_range(0, 15) != 0);
            enc_model(d, ve, c, mt, sym);
            step(1'b0, ve, c, d, sym);
            t = int'(dut.tally_q);
            n_vec++;
            if (tmds_out !== exp_out) begin
                n_err++;
                $display("FAIL rand_sym[%0d]: got %h expected %h", i, tmds_out, exp_out);
            end
            n_vec++;
            if (t != mt) begin
                n_err++;
                $display("FAIL rand_tally[%0d]: got %0d expected %0d", i, t, mt);
            end
            n_vec++;
            if (t > 8 || t < -8) begin
                n_err++;
                $display("FAIL rand_bound[%0d]: got %0d expected within +/-8", i, t);
            end
        end
    endtask

    initial begin
        rst_in     = 1'b1;
        ve_in      = 1'b1;
        control_in = 2'b00;
        data_in    = 8'hA5;
        test_reset();
        test_disparity();
        test_all_ones();
        test_control();
        test_midstream(0);
        test_midstream(1);
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

- Consumes one pixel-channel byte per clock and emits a 10-bit DC-balanced TMDS symbol.
- Video periods: the byte passes through the `tm_choice` transition-minimization stage, then a running-disparity selector that conditionally inverts the low 8 bits.
- Blanking periods: emits one of four fixed control tokens and clears the disparity tally.
- One instance per colour channel (R, G, B) sits between the pixel pipeline and the 10:1 serializer.

## Interface

Parameters: none.

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- clk_in  input  1  pixel clock; all state updates on its rising edge.
- rst_in  input  1  synchronous active-high reset.
- data_in  input  8  pixel byte; sampled only when ve_in=1.
- control_in  input  2  {C1,C0} control bits; sampled only when ve_in=0.
- ve_in  input  1  video-enable. 1 selects the data path; 0 selects the control path.
- tmds_out  output  10  encoded symbol; bit 0 is transmitted first.

## Operation

- q_m[8:0] is the combinational output of `tm_choice` driven by data_in.
- n1 is the popcount of q_m[7:0], range 0..8. n0 = 8 − n1.
- tally is a 5-bit signed register, range −16..+15.
  - Arithmetic is done in 5-bit signed.
  - 2·q_m[8] and 2·~q_m[8] are zero-extended before use.
- Data path (ve_in=1), evaluated in priority order:
  - Case A: tally==0 or n1==4.
    - tmds_out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - If q_m[8]=1: tally += n1−n0. Otherwise: tally += n0−n1.
  - Case B: (tally>0 and n1>n0) or (tally<0 and n0>n1).
    - tmds_out = {1, q_m[8], ~q_m[7:0]}.
    - tally += 2·q_m[8] + (n0−n1).
  - Case C: all other cases.
    - tmds_out = {0, q_m[8], q_m[7:0]}.
    - tally += (n1−n0) − 2·~q_m[8].
- Control path (ve_in=0):
  - tally ← 0.
  - tmds_out by control_in: 00→10'b1101010100, 01→10'b0010101011, 10→10'b0101010100, 11→10'b1010101011.
- Reset: tmds_out ← 10'h000 and tally ← 0 on the clock edge where rst_in=1.
  - Reset overrides ve_in and data_in.
  - Reset mid-stream discards accumulated disparity.
  - The first data symbol after reset is evaluated with tally==0.
- ve_in toggling:
  - 1→0: the control token appears on the next output cycle and tally clears.
  - 0→1: the first data symbol is evaluated with tally==0.
- No back-pressure and no handshake: one symbol is accepted and one produced every cycle.

## Timing

- The output register is clocked by clk_in.
- Latency is 1 cycle: inputs sampled at edge k appear on tmds_out after edge k.
- tally updates on the same edge as tmds_out.
- The next symbol's case selection uses the tally value produced by the previous edge.
- The combinational path is data_in → tm_choice → popcount → case select → output register. It must close at 74.25 MHz, with no retiming required.

## Configuration

- `TMDS_ENCODER_OUTREG_EN` defined:
  - An extra register stage is added after tmds_out. Latency becomes 2 cycles.
  - Reset clears both stages to 10'h000.
  - tally behaviour and sequencing are unchanged.
- Undefined: latency is 1 cycle as described above.
- The three channel instances must be built with the same setting so lanes stay aligned.

## Structure

- Package `tmds_pkg` holds:
  - localparam control tokens CTRL_TOKEN_00/01/10/11 (10-bit).
  - typedef `tally_t` (logic signed [4:0]).
  - typedef `tmds_sym_t` (logic [9:0]).
- Sub-module: one instance of the existing `tm_choice` (d=data_in, q_m=q_m).
- Popcount and case selection live inline in tmds_encoder.

## Test plan

- Reset: hold rst_in=1 for 3 cycles with ve_in=1, data_in=8'hA5 → tmds_out=10'h000 and tally=0 throughout.
- Disparity sequence: ve_in=1, data_in=8'h00 for three consecutive cycles from tally=0 →
  - tmds_out=10'h100, 10'h3FF, 10'h100.
  - tally=−8, +2, −6.
- All-ones byte: data_in=8'hFF from tally=0 → q_m=9'h0FF, tmds_out=10'h200, tally=−8.
- Control tokens: ve_in=0, control_in stepping 00, 01, 10, 11 → tmds_out=10'h354, 10'h0AB, 10'h154, 10'h2AB, with tally=0 after each.
- Mid-stream events:
  - After reaching tally=−6, drop ve_in for 1 cycle, then send data_in=8'h00 → tmds_out=10'h100, confirming tally restarted from 0.
  - Repeat with rst_in pulsed instead of ve_in → same result.
- Long random stream: 10 000 random bytes compared against a golden model → exact match, |tally| ≤ 8 always.
  - Rerun with `TMDS_ENCODER_OUTREG_EN` defined → same symbols, delayed by one extra cycle.
